// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, data_mem control
// codes, FSM states and the alignment rule.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // data_mem MEM control: bit1 = read, bit0 = write
    localparam logic [1:0] MC_IDLE  = 2'b00;
    localparam logic [1:0] MC_READ  = 2'b10;
    localparam logic [1:0] MC_WRITE = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    // Natural alignment; the reserved size is always rejected.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake plus the data_mem port of the load/store unit.
// master = the environment (pipeline and data_mem), slave = mem_lsu.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  mem_ctl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err, mem_ctl, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err, mem_ctl, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering: extracts/extends a load lane from a memory word and
// merges sub-word store data into a word. Purely combinational.
module lsu_lane_align
    import mem_lsu_pkg::*;
#(
    parameter int LITTLE_END = 1
) (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [1:0]  blane;
    logic [7:0]  b;
    logic [15:0] h;

    assign blane = (LITTLE_END != 0) ? lane : ~lane;

    // Lane select for loads and lane replacement for stores
    always_comb begin
        b       = word[{blane, 3'b000} +: 8];
        h       = word[{blane[1], 4'b0000} +: 16];
        ld_data = '0;
        st_word = word;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sgn & b[7]}}, b};
                st_word[{blane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{sgn & h[15]}}, h};
                st_word[{blane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                ld_data = word;
                st_word = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of word-addressed data_mem. Loads and word stores
// take one cycle; byte/half stores are a read (IDLE) then write (RMW).
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int IDX_W      = 10,
    parameter int LITTLE_END = 1
) (
    input  logic     clk,
    input  logic     rst,
    mem_lsu_if.slave bus
);

    state_e                state, state_nxt;
    logic [31:0]           cap_word;
    logic [31:0]           cap_wdata;
    logic [1:0]            cap_lo;
    size_e                 cap_size;
    // Word address split into the data_mem index and the unchecked upper bits
    logic [IDX_W-1:0]      cap_idx;
    logic [29-IDX_W:0]     cap_hi;

    size_e       req_sz;
    logic        req_bad;
    logic        accept;
    logic [31:0] al_word;
    logic [1:0]  al_lane;
    size_e       al_size;
    logic [31:0] al_ld;
    logic [31:0] al_st;

    assign req_sz  = size_e'(bus.req_size);
    assign req_bad = misaligned(req_sz, bus.req_addr[1:0]);
    assign accept  = bus.req_valid && (state == ST_IDLE) && !rst;

    // In IDLE the aligner sees the live read word (load path); in RMW it
    // merges the captured store into the captured word.
    assign al_word = (state == ST_RMW) ? cap_word : bus.mem_rdata;
    assign al_lane = (state == ST_RMW) ? cap_lo   : bus.req_addr[1:0];
    assign al_size = (state == ST_RMW) ? cap_size : req_sz;

    lsu_lane_align #(.LITTLE_END(LITTLE_END)) u_align (
        .word    (al_word),
        .lane    (al_lane),
        .size    (al_size),
        .sgn     (bus.req_signed),
        .wdata   (cap_wdata),
        .ld_data (al_ld),
        .st_word (al_st)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and data_mem drive; reset forces the bus idle so an RMW
    // interrupted by reset never writes.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.mem_ctl   = MC_IDLE;
        bus.mem_addr  = {2'b00, bus.req_addr[31:2]};
        bus.mem_wdata = bus.req_wdata;
        case (state)
            ST_IDLE: begin
                bus.req_ready = !rst;
                if (accept && !req_bad) begin
                    if (!bus.req_we) begin
                        bus.mem_ctl = MC_READ;
                    end else if (req_sz == SZ_WORD) begin
                        bus.mem_ctl = MC_WRITE;
                    end else begin
                        bus.mem_ctl = MC_READ;
                        state_nxt   = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                bus.mem_ctl   = rst ? MC_IDLE : MC_WRITE;
                bus.mem_addr  = {2'b00, cap_hi, cap_idx};
                bus.mem_wdata = al_st;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response pulses and sub-word store capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_data  <= '0;
            cap_word       <= '0;
            cap_wdata      <= '0;
            cap_lo         <= '0;
            cap_size       <= SZ_BYTE;
            cap_idx        <= '0;
            cap_hi         <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            if (accept) begin
                if (req_bad) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b1;
                    bus.resp_data  <= '0;
                end else if (!bus.req_we) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_data  <= al_ld;
                end else if (req_sz != SZ_WORD) begin
                    cap_word  <= bus.mem_rdata;
                    cap_wdata <= bus.req_wdata;
                    cap_lo    <= bus.req_addr[1:0];
                    cap_size  <= req_sz;
                    cap_idx   <= bus.req_addr[IDX_W+1:2];
                    cap_hi    <= bus.req_addr[31:IDX_W+2];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: behavioural data_mem, byte-array reference
// memory, directed scenarios followed by randomized traffic.
module tb_mem_lsu;

    localparam int IDX_W = 10;
    localparam int NW    = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu #(.IDX_W(IDX_W), .LITTLE_END(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_mem: combinational read, write on clock edge
    logic [31:0] dmem [0:NW-1] = '{default: '0};
    assign bus.mem_rdata = dmem[bus.mem_addr[IDX_W-1:0]];
    always @(posedge clk) if (bus.mem_ctl == 2'b01) dmem[bus.mem_addr[IDX_W-1:0]] <= bus.mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: byte-addressed memory, little-endian
    logic [7:0]  rb [0:4*NW-1];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_data = '0;

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << sz;
        return (sz == 2'd3) || ((a % nbytes) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a);
        int bi, n;
        longint v;
        if (sz == 2'd3) return '0;
        bi = int'(a[IDX_W+1:0]);
        n  = 1 << sz;
        v  = 0;
        for (int i = 0; i < n; i++) v += longint'(rb[(bi + i) % (4*NW)]) << (8*i);
        if (sgn && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int bi, n;
        bi = int'(a[IDX_W+1:0]);
        n  = 1 << sz;
        for (int i = 0; i < n; i++) rb[(bi + i) % (4*NW)] = wd[8*i +: 8];
    endfunction

    // One request from IDLE; entered and left at posedge+1.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit          err;
        logic [31:0] exp;
        logic [31:0] wexp;
        logic [1:0]  exp_ctl;
        err     = ref_err(sz, a);
        exp     = ref_load(sz, sgn, a);
        exp_ctl = err ? 2'b00 : (!we ? 2'b10 : (sz == 2'd2 ? 2'b01 : 2'b10));
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL %s ready: got %b want 1", tag, bus.req_ready);
        end
        checks++;
        if (bus.mem_ctl !== exp_ctl) begin
            failures++; $display("FAIL %s mem_ctl: got %b want %b", tag, bus.mem_ctl, exp_ctl);
        end
        if (exp_ctl != 2'b00) begin
            checks++;
            if (bus.mem_addr[IDX_W-1:0] !== a[IDX_W+1:2]) begin
                failures++; $display("FAIL %s mem_addr: got %h want %h", tag, bus.mem_addr[IDX_W-1:0], a[IDX_W+1:2]);
            end
        end
        if (exp_ctl == 2'b01) begin
            checks++;
            if (bus.mem_wdata !== wd) begin
                failures++; $display("FAIL %s mem_wdata: got %h want %h", tag, bus.mem_wdata, wd);
            end
        end
        @(posedge clk); #1;
        if (!err && we) ref_store(sz, a, wd);
        if (!err && we && sz != 2'd2) begin
            // RMW cycle: scramble the request lines to prove they were captured
            bus.req_valid = 1'b0;
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.req_size  = 2'($urandom);
            wexp = ref_load(2'd2, 1'b0, {a[31:2], 2'b00});
            #1;
            checks++;
            if (bus.req_ready !== 1'b0 || bus.mem_ctl !== 2'b01) begin
                failures++; $display("FAIL %s rmw ctl: got ready=%b ctl=%b want ready=0 ctl=01", tag, bus.req_ready, bus.mem_ctl);
            end
            checks++;
            if (bus.mem_wdata !== wexp || bus.mem_addr[IDX_W-1:0] !== a[IDX_W+1:2]) begin
                failures++; $display("FAIL %s rmw write: got %h@%h want %h@%h", tag, bus.mem_wdata, bus.mem_addr[IDX_W-1:0], wexp, a[IDX_W+1:2]);
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (bus.resp_valid !== (err || !we) || bus.resp_err !== err) begin
            failures++; $display("FAIL %s resp flags: got v=%b e=%b want v=%b e=%b", tag, bus.resp_valid, bus.resp_err, err || !we, err);
        end
        if (err) last_data = '0;
        else if (!we) last_data = exp;
        checks++;
        if (bus.resp_data !== last_data) begin
            failures++; $display("FAIL %s resp_data: got %h want %h", tag, bus.resp_data, last_data);
        end
    endtask

    // One idle cycle: bus quiet, pulses gone, resp_data held.
    task automatic idle_check(input string tag);
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (bus.mem_ctl !== 2'b00 || bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL %s idle: got ctl=%b ready=%b want 00/1", tag, bus.mem_ctl, bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_data !== last_data) begin
            failures++; $display("FAIL %s hold: got v=%b e=%b d=%h want 0/0/%h", tag, bus.resp_valid, bus.resp_err, bus.resp_data, last_data);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'hDEAD_BEEF;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_ctl !== 2'b00) begin
            failures++; $display("FAIL reset ctl: got ready=%b ctl=%b want 0/00", bus.req_ready, bus.mem_ctl);
        end
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h0) begin
            failures++; $display("FAIL reset resp: got v=%b e=%b d=%h want 0/0/0", bus.resp_valid, bus.resp_err, bus.resp_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.req_valid = 1'b0;
        checks++;
        if (dmem[0] !== 32'h0) begin
            failures++; $display("FAIL reset nowrite: got %h want 0", dmem[0]);
        end
        last_data = '0;
    endtask

    task automatic test_store_load();
        issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, "sw4");
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4");
        checks++;
        if (bus.resp_data !== 32'h1122_3344) begin
            failures++; $display("FAIL lw4 const: got %h want 11223344", bus.resp_data);
        end
        idle_check("lw4_pulse");
    endtask

    task automatic test_byte_store();
        issue(1'b1, 2'd0, 1'b0, 32'h5, 32'hFFFF_FFAB, "sb5");
        checks++;
        if (dmem[1] !== 32'h1122_AB44) begin
            failures++; $display("FAIL sb5 word: got %h want 1122ab44", dmem[1]);
        end
        idle_check("sb5_idle");
    endtask

    task automatic test_sign_ext();
        issue(1'b1, 2'd0, 1'b0, 32'h8, 32'h80, "sb8");
        issue(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, "lb8s");
        checks++;
        if (bus.resp_data !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL lb8s const: got %h want ffffff80", bus.resp_data);
        end
        issue(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, "lb8u");
        checks++;
        if (bus.resp_data !== 32'h0000_0080) begin
            failures++; $display("FAIL lb8u const: got %h want 00000080", bus.resp_data);
        end
        issue(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, "lh6s");
        checks++;
        if (bus.resp_data !== 32'h0000_1122) begin
            failures++; $display("FAIL lh6s const: got %h want 00001122", bus.resp_data);
        end
    endtask

    task automatic test_misaligned();
        issue(1'b1, 2'd1, 1'b0, 32'h3, 32'hBEEF, "sh3");
        issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, "lw2");
        issue(1'b1, 2'd3, 1'b0, 32'h4, 32'h5555_5555, "s_rsvd");
        issue(1'b0, 2'd3, 1'b1, 32'h0, 32'h0, "l_rsvd");
        checks++;
        if (dmem[0] !== 32'h0 || dmem[1] !== 32'h1122_AB44) begin
            failures++; $display("FAIL mis nowrite: got %h %h want 00000000 1122ab44", dmem[0], dmem[1]);
        end
        idle_check("mis_idle");
    endtask

    task automatic test_reset_rmw();
        issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, "sw4b");
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h4; bus.req_wdata = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_ctl !== 2'b00 || bus.req_ready !== 1'b0) begin
            failures++; $display("FAIL rstrmw ctl: got ctl=%b ready=%b want 00/0", bus.mem_ctl, bus.req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_data = '0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || dmem[1] !== 32'h1122_3344) begin
            failures++; $display("FAIL rstrmw after: got ready=%b word=%h want 1/11223344", bus.req_ready, dmem[1]);
        end
        @(posedge clk); #1;
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "rstrmw_lw");
        checks++;
        if (bus.resp_data !== 32'h1122_3344) begin
            failures++; $display("FAIL rstrmw_lw const: got %h want 11223344", bus.resp_data);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        issue(1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A5_0001, "b2b_sw0");
        issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h5A5A_0002, "b2b_sw4");
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "b2b_lw0");
        checks++;
        if (cyc - c0 !== 3 || bus.resp_data !== 32'hA5A5_0001) begin
            failures++; $display("FAIL b2b: got cycles=%0d data=%h want 3/a5a50001", cyc - c0, bus.resp_data);
        end
        idle_check("b2b_idle");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        for (int n = 0; n < 300; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            // index kept in a small window, upper bits random to exercise wrap
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
            if ($urandom_range(0, 4) == 0) idle_check("rnd_idle");
        end
    endtask

    initial begin
        for (int i = 0; i < 4*NW; i++) rb[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        @(posedge clk); #1;
        test_store_load();
        test_byte_store();
        test_sign_ext();
        test_misaligned();
        test_reset_rmw();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
